// File: rtl/waveform_meter.sv
// Window-based measurement of an unsigned sample stream: max, min, peak-to-peak
// and the period between rising midpoint crossings (with hysteresis).
module waveform_meter #(
    parameter int DATA_W = 8,
    parameter int WINDOW = 1024,
    parameter int PER_W  = 16,
    parameter int HYST   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              meas_valid,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] pk2pk_out,
    output logic [PER_W-1:0]  period_out,
    output logic              no_signal
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [DATA_W:0]   HYST_X   = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0]   MAX_X    = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W-1:0] MID_RST  = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic {UNARMED, ARMED} xstate_t;

    xstate_t           state, state_next;
    logic [WIN_W-1:0]  win_cnt;
    logic [DATA_W-1:0] run_max, run_min, mid;
    logic [1:0]        cross_cnt;
    logic [PER_W-1:0]  per_cnt, cand_period;

    logic              pend, pend_sig;
    logic [DATA_W-1:0] pend_max, pend_min;
    logic [PER_W-1:0]  pend_period;

    logic [DATA_W:0]   samp_ext, mid_ext, lo, hi, hi_raw, mid_sum;
    logic [DATA_W-1:0] max_next, min_next;
    logic [PER_W-1:0]  per_plus, cand_next;
    logic [1:0]        cross_next;
    logic              crossing, win_end;

    // Thresholds are widened by one bit so the hysteresis band clamps instead of wrapping.
    always_comb begin
        samp_ext = {1'b0, sample_in};
        mid_ext  = {1'b0, mid};
        lo       = (mid_ext >= HYST_X) ? mid_ext - HYST_X : '0;
        hi_raw   = mid_ext + HYST_X;
        hi       = (hi_raw > MAX_X) ? MAX_X : hi_raw;
        mid_sum  = {1'b0, pend_max} + {1'b0, pend_min};
    end

    // Crossing detector: arm below lo, report a rising crossing on reaching hi.
    always_comb begin
        state_next = state;
        crossing   = 1'b0;
        if (sample_valid) begin
            case (state)
                UNARMED: if (samp_ext < lo) state_next = ARMED;
                ARMED: begin
                    if (samp_ext >= hi) begin
                        state_next = UNARMED;
                        crossing   = 1'b1;
                    end
                end
                default: state_next = UNARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= UNARMED;
        else     state <= state_next;
    end

    // Values including the current sample; the window's last sample is folded in here.
    always_comb begin
        max_next   = (sample_in > run_max) ? sample_in : run_max;
        min_next   = (sample_in < run_min) ? sample_in : run_min;
        per_plus   = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
        cand_next  = (crossing && cross_cnt != 2'd0) ? per_plus : cand_period;
        cross_next = (crossing && cross_cnt != 2'd2) ? cross_cnt + 2'd1 : cross_cnt;
        win_end    = sample_valid && (win_cnt == WIN_LAST);
    end

    // Window results are staged in pend_* so the next window can start on the very next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            run_max     <= '0;
            run_min     <= '1;
            cross_cnt   <= '0;
            per_cnt     <= '0;
            cand_period <= '0;
            mid         <= MID_RST;
            pend        <= 1'b0;
            pend_sig    <= 1'b0;
            pend_max    <= '0;
            pend_min    <= '0;
            pend_period <= '0;
            meas_valid  <= 1'b0;
            max_out     <= '0;
            min_out     <= '0;
            pk2pk_out   <= '0;
            period_out  <= '0;
            no_signal   <= 1'b0;
        end else begin
            meas_valid <= pend;
            if (pend) begin
                pend       <= 1'b0;
                max_out    <= pend_max;
                min_out    <= pend_min;
                pk2pk_out  <= pend_max - pend_min;
                period_out <= pend_sig ? pend_period : '0;
                no_signal  <= !pend_sig;
                mid        <= DATA_W'(mid_sum >> 1);
            end
            if (sample_valid) begin
                per_cnt     <= crossing ? '0 : per_plus;
                cand_period <= cand_next;
                if (win_end) begin
                    pend        <= 1'b1;
                    pend_max    <= max_next;
                    pend_min    <= min_next;
                    pend_period <= cand_next;
                    pend_sig    <= (cross_next == 2'd2);
                    win_cnt     <= '0;
                    run_max     <= '0;
                    run_min     <= '1;
                    cross_cnt   <= '0;
                end else begin
                    win_cnt   <= win_cnt + 1'b1;
                    run_max   <= max_next;
                    run_min   <= min_next;
                    cross_cnt <= cross_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_waveform_meter.sv
// Directed bench for waveform_meter: ramps, constants, squares, jitter and mid-window reset,
// with a second instance using an 8-bit period counter to exercise saturation.
module tb_waveform_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [7:0] sample_in;

    logic        meas_valid, no_signal;
    logic [7:0]  max_out, min_out, pk2pk_out;
    logic [15:0] period_out;

    logic       meas_valid8, no_signal8;
    logic [7:0] max_out8, min_out8, pk2pk_out8, period_out8;

    waveform_meter dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .meas_valid(meas_valid), .max_out(max_out), .min_out(min_out),
        .pk2pk_out(pk2pk_out), .period_out(period_out), .no_signal(no_signal)
    );

    waveform_meter #(.PER_W(8)) dut8 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .meas_valid(meas_valid8), .max_out(max_out8), .min_out(min_out8),
        .pk2pk_out(pk2pk_out8), .period_out(period_out8), .no_signal(no_signal8)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          p_cnt = 0;
    int          p8_cnt = 0;
    int          double_pulse = 0;
    logic        prev_mv = 1'b0;
    int          p_cyc [16];
    logic [7:0]  p_max [16];
    logic [7:0]  p_min [16];
    logic [7:0]  p_pk  [16];
    logic [15:0] p_per [16];
    logic        p_ns  [16];
    logic [7:0]  p8_per[16];

    int n_checks = 0;
    int n_fail   = 0;
    int base;
    int rel;

    // Pulse recorder: snapshots results 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (meas_valid && p_cnt < 16) begin
            p_cyc[p_cnt] = cyc;
            p_max[p_cnt] = max_out;
            p_min[p_cnt] = min_out;
            p_pk[p_cnt]  = pk2pk_out;
            p_per[p_cnt] = period_out;
            p_ns[p_cnt]  = no_signal;
        end
        if (meas_valid) p_cnt++;
        if (meas_valid && prev_mv) double_pulse++;
        prev_mv = meas_valid;
        if (meas_valid8 && p8_cnt < 16) p8_per[p8_cnt] = period_out8;
        if (meas_valid8) p8_cnt++;
    end

    task automatic apply_stimulus(input logic v, input logic [7:0] s);
        sample_valid = v;
        sample_in    = s;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = p_cnt;
        rel  = cyc;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_window(input string tag, input int idx, input int emax, input int emin,
                                input int epk, input int eper, input int ens);
        check_output({tag, " max"},       32'(p_max[idx]), 32'(emax));
        check_output({tag, " min"},       32'(p_min[idx]), 32'(emin));
        check_output({tag, " pk2pk"},     32'(p_pk[idx]),  32'(epk));
        check_output({tag, " period"},    32'(p_per[idx]), 32'(eper));
        check_output({tag, " no_signal"}, 32'(p_ns[idx]),  32'(ens));
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 8'h00;

        // Reset state, then full-scale ramp of period 256 across two windows.
        do_reset();
        check_output("reset meas_valid", 32'(meas_valid), 32'd0);
        check_output("reset max_out",    32'(max_out),    32'd0);
        check_output("reset no_signal",  32'(no_signal),  32'd0);
        for (int i = 0; i < 2048; i++) apply_stimulus(1'b1, 8'(i));
        apply_stimulus(1'b0, 8'h00);
        check_output("ramp pulse count", 32'(p_cnt - base), 32'd2);
        check_output("ramp pulse1 time", 32'(p_cyc[base] - rel), 32'd1025);
        check_output("ramp pulse2 time", 32'(p_cyc[base + 1] - rel), 32'd2049);
        check_window("ramp w1", base, 255, 0, 255, 256, 0);
        check_window("ramp w2", base + 1, 255, 0, 255, 256, 0);
        check_output("ramp sat period8", 32'(p8_per[base + 1]), 32'd255);
        apply_stimulus(1'b0, 8'h00);
        check_output("hold meas_valid low", 32'(meas_valid), 32'd0);
        check_output("hold max_out",        32'(max_out),    32'd255);
        check_output("hold period_out",     32'(period_out), 32'd256);

        // Reset clears results after a measurement.
        do_reset();
        check_output("rereset max_out",    32'(max_out),    32'd0);
        check_output("rereset pk2pk_out",  32'(pk2pk_out),  32'd0);
        check_output("rereset period_out", 32'(period_out), 32'd0);
        check_output("rereset min_out",    32'(min_out),    32'd0);

        // Constant midscale input.
        for (int i = 0; i < 1024; i++) apply_stimulus(1'b1, 8'h80);
        apply_stimulus(1'b0, 8'h00);
        check_output("const pulse count", 32'(p_cnt - base), 32'd1);
        check_window("const", base, 128, 128, 0, 0, 1);

        // Jitter inside the hysteresis band never arms.
        do_reset();
        for (int i = 0; i < 1024; i++) apply_stimulus(1'b1, 8'(8'h7E + 8'(i % 5)));
        apply_stimulus(1'b0, 8'h00);
        check_window("jitter", base, 130, 126, 4, 0, 1);

        // Square 0x10/0xF0, 50 each, valid every other cycle with junk on idle cycles.
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            apply_stimulus(1'b1, ((i / 50) % 2 == 1) ? 8'hF0 : 8'h10);
            apply_stimulus(1'b0, 8'h00);
        end
        apply_stimulus(1'b0, 8'h00);
        check_output("sq100 pulse count", 32'(p_cnt - base), 32'd1);
        check_output("sq100 pulse time", 32'(p_cyc[base] - rel), 32'd2048);
        check_window("sq100", base, 240, 16, 224, 100, 0);
        check_output("sq100 period8", 32'(p8_per[base]), 32'd100);

        // Square period 300: 16-bit counter reads 300, 8-bit counter saturates.
        do_reset();
        for (int i = 0; i < 1024; i++) apply_stimulus(1'b1, ((i / 150) % 2 == 1) ? 8'hF0 : 8'h10);
        apply_stimulus(1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00);
        check_window("sq300", base, 240, 16, 224, 300, 0);
        check_output("sq300 period8 saturated", 32'(p8_per[base]), 32'd255);

        // Reset 500 samples into a window, then a full window of ramp.
        do_reset();
        for (int i = 0; i < 500; i++) apply_stimulus(1'b1, 8'(i));
        do_reset();
        for (int i = 0; i < 1024; i++) apply_stimulus(1'b1, 8'(i));
        apply_stimulus(1'b0, 8'h00);
        apply_stimulus(1'b0, 8'h00);
        check_output("midrst pulse count", 32'(p_cnt - base), 32'd1);
        check_output("midrst pulse time", 32'(p_cyc[base] - rel), 32'd1025);
        check_window("midrst", base, 255, 0, 255, 256, 0);

        check_output("no back-to-back pulses", 32'(double_pulse), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
